sprite_linebuf: RTL and testbench



---
 rtl/sprite_linebuf_pkg.sv | 23 ++
 rtl/sprite_linebuf_bank.sv | 35 +++
 rtl/sprite_linebuf.sv | 192 +++++++++++++++++++
 tb/tb_sprite_linebuf.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_linebuf_pkg.sv
// Shared definitions for the double-buffered sprite line buffer:
// entry field layout, default geometry and the sweep FSM encoding.
package sprite_linebuf_pkg;

  localparam int IDX_W_DEFAULT   = 10;
  localparam int DATA_W_DEFAULT  = 16;
  localparam int VISIBLE_DEFAULT = 640;

  // Entry layout: {collision[15:12], 2'b0, z[9:8], color[7:0]}
  localparam int COLL_MSB  = 15;
  localparam int COLL_LSB  = 12;
  localparam int Z_MSB     = 9;
  localparam int Z_LSB     = 8;
  localparam int COLOR_MSB = 7;
  localparam int COLOR_LSB = 0;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SWEEP = 2'd2
  } state_e;

endpackage

// File: rtl/sprite_linebuf_bank.sv
// One line-buffer bank: simple dual-port RAM, synchronous read-first read
// port and one write port. No reset; contents are cleared by the owner.
module linebuf_bank
  import sprite_linebuf_pkg::*;
#(
  parameter int IDX_W  = IDX_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem_q [2**IDX_W];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  always_comb begin
    rd_data_d = mem_q[rd_addr];
  end

  // The read samples the pre-edge contents, so a same-address write is read-first.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sprite_linebuf.sv
// Double-buffered sprite line buffer: render bank serves the renderer's RMW
// port, display bank is read by the composer and cleared behind the read.
// Optional macro SPRITE_LINEBUF_FWD_EN: write-first bypass on the render port.
module sprite_linebuf
  import sprite_linebuf_pkg::*;
#(
  parameter int IDX_W   = IDX_W_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int VISIBLE = VISIBLE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_render_start,
  input  logic [IDX_W-1:0]  linebuf_rdidx,
  output logic [DATA_W-1:0] linebuf_rddata,
  input  logic [IDX_W-1:0]  linebuf_wridx,
  input  logic [DATA_W-1:0] linebuf_wrdata,
  input  logic              linebuf_wren,
  input  logic              disp_rden,
  input  logic [IDX_W-1:0]  disp_idx,
  output logic [DATA_W-1:0] disp_rddata,
  output logic              busy,
  output logic              sweep_overrun
);

  localparam logic [IDX_W-1:0] VIS_IDX  = IDX_W'(VISIBLE);
  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              bank_sel_q, bank_sel_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              out_en_q, out_en_d;
  logic              rd_sel_q, rd_sel_d;
  logic              fwd_hit_q, fwd_hit_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

  logic              init_s;
  logic              sweep_s;
  logic [1:0]                   b_we_s;
  logic [1:0][IDX_W-1:0]        b_waddr_s;
  logic [1:0][DATA_W-1:0]       b_wdata_s;
  logic [1:0][IDX_W-1:0]        b_raddr_s;
  logic [1:0][DATA_W-1:0]       b_rdata_s;

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      bank_sel_q <= 1'b0;
      busy_q     <= 1'b1;
      overrun_q  <= 1'b0;
      out_en_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bank_sel_q <= bank_sel_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      out_en_q   <= out_en_d;
      rd_sel_q   <= rd_sel_d;
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  // Next-state logic; a swap during SWEEP restarts the tail on the new bank.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      ST_IDLE: begin
        if (line_render_start) begin
          state_d = ST_SWEEP;
          cnt_d   = VIS_IDX;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_SWEEP: begin
        if (line_render_start) begin
          cnt_d = VIS_IDX;
        end else if (!disp_rden) begin
          if (cnt_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: bank port steering and next values of registered outputs.
  always_comb begin
    init_s     = (state_q == ST_INIT);
    sweep_s    = (state_q == ST_SWEEP);
    bank_sel_d = bank_sel_q ^ line_render_start;
    busy_d     = (state_d != ST_IDLE);
    overrun_d  = sweep_s & line_render_start;
    out_en_d   = ~init_s;
    rd_sel_d   = bank_sel_q;
    b_we_s     = '0;
    b_waddr_s  = '0;
    b_wdata_s  = '0;
    b_raddr_s  = '0;
    for (int i = 0; i < 2; i++) begin
      if (bank_sel_q == i[0]) begin
        b_raddr_s[i] = linebuf_rdidx;
      end else begin
        b_raddr_s[i] = disp_idx;
      end
      if (rst) begin
        b_we_s[i] = 1'b0;
      end else if (init_s) begin
        b_we_s[i]    = 1'b1;
        b_waddr_s[i] = cnt_q;
      end else if (bank_sel_q == i[0]) begin
        b_we_s[i]    = linebuf_wren;
        b_waddr_s[i] = linebuf_wridx;
        b_wdata_s[i] = linebuf_wrdata;
      end else if (disp_rden) begin
        // Composer clear-behind owns the write port; the sweep stalls.
        b_we_s[i]    = 1'b1;
        b_waddr_s[i] = disp_idx;
      end else if (sweep_s) begin
        b_we_s[i]    = 1'b1;
        b_waddr_s[i] = cnt_q;
      end else begin
        b_we_s[i] = 1'b0;
      end
    end
`ifdef SPRITE_LINEBUF_FWD_EN
    fwd_hit_d  = linebuf_wren & ~init_s & (linebuf_rdidx == linebuf_wridx);
    fwd_data_d = linebuf_wrdata;
`else
    fwd_hit_d  = 1'b0;
    fwd_data_d = '0;
`endif
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    linebuf_bank #(
      .IDX_W  (IDX_W),
      .DATA_W (DATA_W)
    ) u_bank (
      .clk     (clk),
      .rd_addr (b_raddr_s[g]),
      .rd_data (b_rdata_s[g]),
      .wr_en   (b_we_s[g]),
      .wr_addr (b_waddr_s[g]),
      .wr_data (b_wdata_s[g])
    );
  end

  // Read data uses the bank selection that was live when the read was issued.
  always_comb begin
    if (!out_en_q) begin
      linebuf_rddata = '0;
      disp_rddata    = '0;
    end else if (fwd_hit_q) begin
      linebuf_rddata = fwd_data_q;
      disp_rddata    = b_rdata_s[~rd_sel_q];
    end else begin
      linebuf_rddata = b_rdata_s[rd_sel_q];
      disp_rddata    = b_rdata_s[~rd_sel_q];
    end
  end

  assign busy          = busy_q;
  assign sweep_overrun = overrun_q;

endmodule

// File: tb/tb_sprite_linebuf.sv
// Self-checking bench for sprite_linebuf: array-level reference model checked
// every cycle, plus directed literal checks. Honours SPRITE_LINEBUF_FWD_EN.
module tb_sprite_linebuf;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_render_start;
  logic [9:0]  linebuf_rdidx;
  logic [15:0] linebuf_rddata;
  logic [9:0]  linebuf_wridx;
  logic [15:0] linebuf_wrdata;
  logic        linebuf_wren;
  logic        disp_rden;
  logic [9:0]  disp_idx;
  logic [15:0] disp_rddata;
  logic        busy;
  logic        sweep_overrun;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  sprite_linebuf dut (
    .clk               (clk),
    .rst               (rst),
    .line_render_start (line_render_start),
    .linebuf_rdidx     (linebuf_rdidx),
    .linebuf_rddata    (linebuf_rddata),
    .linebuf_wridx     (linebuf_wridx),
    .linebuf_wrdata    (linebuf_wrdata),
    .linebuf_wren      (linebuf_wren),
    .disp_rden         (disp_rden),
    .disp_idx          (disp_idx),
    .disp_rddata       (disp_rddata),
    .busy              (busy),
    .sweep_overrun     (sweep_overrun)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two plain arrays, a mode and a sweep position.
  localparam int M_INIT = 0, M_IDLE = 1, M_SWEEP = 2;
  logic [15:0] m_mem [2][1024];
  int          m_mode = M_INIT;
  int          m_cnt  = 0;
  int          m_sel  = 0;
  logic [15:0] e_rd, e_dd;
  logic        e_busy, e_ovr;

  initial begin
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < 1024; k++) m_mem[b][k] = 16'h0000;
  end

  always @(posedge clk) begin : model
    if (rst) begin
      e_rd = 16'h0000; e_dd = 16'h0000; e_busy = 1'b1; e_ovr = 1'b0;
      m_mode = M_INIT; m_cnt = 0; m_sel = 0;
    end else begin
      if (m_mode == M_INIT) begin
        e_rd = 16'h0000;
        e_dd = 16'h0000;
      end else begin
        e_rd = m_mem[m_sel][linebuf_rdidx];
`ifdef SPRITE_LINEBUF_FWD_EN
        if (linebuf_wren && linebuf_rdidx == linebuf_wridx) e_rd = linebuf_wrdata;
`endif
        e_dd = m_mem[1-m_sel][disp_idx];
      end
      e_ovr = (m_mode == M_SWEEP) && line_render_start;
      if (m_mode == M_INIT) begin
        m_mem[0][m_cnt] = 16'h0000;
        m_mem[1][m_cnt] = 16'h0000;
        if (m_cnt == 1023) begin m_mode = M_IDLE; m_cnt = 0; end
        else m_cnt = m_cnt + 1;
      end else begin
        if (linebuf_wren) m_mem[m_sel][linebuf_wridx] = linebuf_wrdata;
        if (disp_rden) m_mem[1-m_sel][disp_idx] = 16'h0000;
        else if (m_mode == M_SWEEP) m_mem[1-m_sel][m_cnt] = 16'h0000;
        if (m_mode == M_IDLE) begin
          if (line_render_start) begin m_mode = M_SWEEP; m_cnt = 640; end
        end else if (line_render_start) begin
          m_cnt = 640;
        end else if (!disp_rden) begin
          if (m_cnt == 1023) m_mode = M_IDLE;
          else m_cnt = m_cnt + 1;
        end
      end
      if (line_render_start) m_sel = 1 - m_sel;
      e_busy = (m_mode != M_IDLE);
    end
    #1;
    check("model_rddata", linebuf_rddata, e_rd);
    check("model_disp_rddata", disp_rddata, e_dd);
    check("model_busy", {15'd0, busy}, {15'd0, e_busy});
    check("model_overrun", {15'd0, sweep_overrun}, {15'd0, e_ovr});
  end

  task automatic idle_in();
    line_render_start = 1'b0;
    linebuf_wren      = 1'b0;
    disp_rden         = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {15'd0, busy}, 16'h0000);
  endtask

  task automatic random_cycles(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      line_render_start = ($urandom_range(0, 299) == 0);
      linebuf_rdidx     = 10'($urandom_range(0, 1023));
      linebuf_wridx     = ($urandom_range(0, 3) == 0) ? linebuf_rdidx : 10'($urandom_range(0, 1023));
      linebuf_wrdata    = 16'($urandom);
      linebuf_wren      = $urandom_range(0, 1) == 1;
      disp_rden         = $urandom_range(0, 1) == 1;
      disp_idx          = ($urandom_range(0, 1) == 1) ? linebuf_wridx : 10'($urandom_range(0, 1023));
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    idle_in();
    linebuf_rdidx = 10'd0; linebuf_wridx = 10'd0; linebuf_wrdata = 16'h0000; disp_idx = 10'd0;
    repeat (2) @(negedge clk);
    check("reset_busy", {15'd0, busy}, 16'h0001);
    check("reset_rddata", linebuf_rddata, 16'h0000);
    check("reset_disp_rddata", disp_rddata, 16'h0000);
    check("reset_overrun", {15'd0, sweep_overrun}, 16'h0000);

    rst = 1'b0;
    wait_idle("init_done", 2000, n);
    check("init_cycles", 16'(n), 16'd1024);

    // Render write idx 5, swap, composer reads it twice (clear-behind).
    linebuf_wren = 1'b1; linebuf_wridx = 10'd5; linebuf_wrdata = 16'h1203;
    @(negedge clk);
    linebuf_wren = 1'b0; line_render_start = 1'b1;
    @(negedge clk);
    line_render_start = 1'b0; disp_rden = 1'b1; disp_idx = 10'd5;
    @(negedge clk);
    check("disp_read_idx5", disp_rddata, 16'h1203);
    @(negedge clk);
    check("disp_reread_idx5", disp_rddata, 16'h0000);
    disp_rden = 1'b0;

    // Same-cycle write and read of idx 7 on the render port.
    linebuf_wren = 1'b1; linebuf_wridx = 10'd7; linebuf_rdidx = 10'd7; linebuf_wrdata = 16'h0155;
    @(negedge clk);
`ifdef SPRITE_LINEBUF_FWD_EN
    check("fwd_idx7", linebuf_rddata, 16'h0155);
`else
    check("nofwd_idx7", linebuf_rddata, 16'h0000);
`endif
    linebuf_wren = 1'b0;
    @(negedge clk);
    check("readback_idx7", linebuf_rddata, 16'h0155);

    // Entry beyond the visible range is cleared by the tail sweep.
    wait_idle("sweep1_done", 2000, n);
    linebuf_wren = 1'b1; linebuf_wridx = 10'd1000; linebuf_wrdata = 16'hF0FF;
    @(negedge clk);
    linebuf_wren = 1'b0; line_render_start = 1'b1;
    @(negedge clk);
    line_render_start = 1'b0;
    wait_idle("tail_sweep_done", 400, n);
    line_render_start = 1'b1;
    @(negedge clk);
    line_render_start = 1'b0; linebuf_rdidx = 10'd1000;
    @(negedge clk);
    check("idx1000_cleared", linebuf_rddata, 16'h0000);

    // Composer reading every cycle stalls the sweep; a swap then overruns.
    disp_rden = 1'b1;
    for (int c = 0; c < 500; c++) begin
      disp_idx = 10'($urandom_range(0, 639));
      @(negedge clk);
    end
    check("stall_busy", {15'd0, busy}, 16'h0001);
    line_render_start = 1'b1;
    @(negedge clk);
    check("overrun_pulse", {15'd0, sweep_overrun}, 16'h0001);
    line_render_start = 1'b0;
    @(negedge clk);
    check("overrun_clear", {15'd0, sweep_overrun}, 16'h0000);
    check("overrun_busy", {15'd0, busy}, 16'h0001);
    disp_rden = 1'b0;

    random_cycles(3000);

    // Reset in the middle of a sweep.
    idle_in();
    @(negedge clk);
    line_render_start = 1'b1;
    @(negedge clk);
    line_render_start = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1; disp_rden = 1'b1; disp_idx = 10'd3; linebuf_rdidx = 10'd7;
    @(negedge clk);
    check("midrst_busy", {15'd0, busy}, 16'h0001);
    check("midrst_rddata", linebuf_rddata, 16'h0000);
    check("midrst_disp_rddata", disp_rddata, 16'h0000);
    rst = 1'b0; disp_rden = 1'b0;
    wait_idle("reinit_done", 2000, n);
    check("reinit_cycles", 16'(n), 16'd1024);

    random_cycles(1500);
    idle_in();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
